// File: rtl/hw_pointer_writeback_pkg.sv
// Shared definitions for the hardware pointer write-back path: TLP
// fmt/type codes (also used by the receive path) and the one-hot TX states.
package hw_pointer_writeback_pkg;

   localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'h40;
   localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'h60;

   // Payload is a single 64-bit pointer: two DWs.
   localparam logic [9:0] WB_LENGTH_DW = 10'd2;

   typedef enum logic [7:0] {
      ST_IDLE = 8'h01,
      ST_ARB  = 8'h02,
      ST_B0   = 8'h04,
      ST_B1   = 8'h08,
      ST_B2   = 8'h10
   } wb_state_e;

   // Reorders a DW so the least significant pointer byte lands in the
   // first byte lane on the wire (little-endian host memory image).
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/hw_pointer_writeback_tlp_hdr_gen.sv
// Combinational builder for the three 64-bit beats of the pointer
// write-back TLP, in either MWr32 (3-DW header) or MWr64 (4-DW header) form.
module tlp_hdr_gen
   import hw_pointer_writeback_pkg::*;
(
   input  logic        fmt64,
   input  logic [15:0] completer_id,
   input  logic [63:2] addr,
   input  logic [63:0] ptr,
   output logic [63:0] beat0,
   output logic [63:0] beat1,
   output logic [63:0] beat2,
   output logic [7:0]  trem_last_n
);

   logic [31:0] hdr_dw0;
   logic [31:0] hdr_dw1;
   logic [31:0] addr_lo;
   logic [31:0] data_dw0;
   logic [31:0] data_dw1;

   // Assemble header, address and payload DWs and pack them two per beat.
   always_comb begin
      // R, fmt/type, R, TC, R, TD, EP, attr, AT, length
      hdr_dw0  = {1'b0, (fmt64 ? MEM_WR64_FMT_TYPE : MEM_WR32_FMT_TYPE),
                  1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, WB_LENGTH_DW};
      // requester ID, tag 0, last BE, first BE
      hdr_dw1  = {completer_id, 8'h00, 4'hF, 4'hF};
      addr_lo  = {addr[31:2], 2'b00};
      data_dw0 = bswap32(ptr[31:0]);
      data_dw1 = bswap32(ptr[63:32]);

      beat0 = {hdr_dw0, hdr_dw1};
      if (fmt64) begin
         beat1       = {addr[63:32], addr_lo};
         beat2       = {data_dw0, data_dw1};
         trem_last_n = 8'h00;
      end else begin
         // The 3-DW header leaves room for the first data DW in beat 1,
         // so the last beat carries only one valid DW.
         beat1       = {addr_lo, data_dw0};
         beat2       = {data_dw1, 32'h0000_0000};
         trem_last_n = 8'h0F;
      end
   end

endmodule

// File: rtl/hw_pointer_writeback.sv
// Posts the hardware ring pointer into host memory as a memory-write TLP on
// the TRN TX interface. Requests coalesce into a pending flag; the TX bus is
// obtained from the shared arbiter and held for the three beats of one TLP.
module hw_pointer_writeback
   import hw_pointer_writeback_pkg::*;
#(
   parameter int BUF_AV_BIT = 1
) (
   input  logic        trn_clk,
   input  logic        reset,
   input  logic [63:0] hw_pointer,
   input  logic [63:0] host_addr,
   input  logic [15:0] cfg_completer_id,
   input  logic        update_req,
   output logic        update_done,
   output logic        tx_req,
   input  logic        tx_grant,
   output logic [63:0] trn_td,
   output logic [7:0]  trn_trem_n,
   output logic        trn_tsof_n,
   output logic        trn_teof_n,
   output logic        trn_tsrc_rdy_n,
   output logic        trn_tsrc_dsc_n,
   input  logic        trn_tdst_rdy_n,
   input  logic        trn_tdst_dsc_n,
   input  logic [3:0]  trn_tbuf_av
);

   wb_state_e   state_q, state_d;
   logic        pending_q, pending_d;
   logic        done_q, done_d;
   logic        fmt64_q, fmt64_d;
   logic [63:0] ptr_q, ptr_d;
   logic [63:2] addr_q, addr_d;
   logic [15:0] id_q, id_d;
   logic [63:0] td_q, td_d;
   logic [7:0]  trem_q, trem_d;
   logic        sof_n_q, sof_n_d;
   logic        eof_n_q, eof_n_d;
   logic        src_rdy_n_q, src_rdy_n_d;

   logic        in_beat;
   logic        abort;
   logic        beat_acc;
   logic        launch;

   logic [63:0] beat0, beat1, beat2;
   logic [7:0]  trem_last_n;

   // Low address bits are implied by 8-byte alignment; only one credit bit matters.
   logic        unused_inputs;
   assign unused_inputs = ^{host_addr[1:0], trn_tbuf_av};

   // Beat words are built from the values that will be held next cycle, so
   // the registered TRN outputs already carry B0 on the first beat cycle.
   tlp_hdr_gen u_hdr_gen (
      .fmt64        (fmt64_d),
      .completer_id (id_d),
      .addr         (addr_d),
      .ptr          (ptr_d),
      .beat0        (beat0),
      .beat1        (beat1),
      .beat2        (beat2),
      .trem_last_n  (trem_last_n)
   );

   // Control state and registered TRN framing, cleared by reset.
   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         done_q      <= 1'b0;
         td_q        <= 64'h0;
         trem_q      <= 8'h00;
         sof_n_q     <= 1'b1;
         eof_n_q     <= 1'b1;
         src_rdy_n_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         done_q      <= done_d;
         td_q        <= td_d;
         trem_q      <= trem_d;
         sof_n_q     <= sof_n_d;
         eof_n_q     <= eof_n_d;
         src_rdy_n_q <= src_rdy_n_d;
      end
   end

   // Per-TLP sample of pointer, address, ID and format; data only, no reset.
   always_ff @(posedge trn_clk) begin
      fmt64_q <= fmt64_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
   end

   // Next-state logic: arbitration, beat advance on ready, abandon on discontinue.
   always_comb begin
      in_beat  = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2);
      abort    = in_beat && !trn_tdst_dsc_n;
      beat_acc = in_beat && trn_tdst_dsc_n && !trn_tdst_rdy_n;
      launch   = (state_q == ST_ARB) && tx_grant && trn_tbuf_av[BUF_AV_BIT];
      state_d  = state_q;
      case (state_q)
         ST_IDLE: if (pending_q) state_d = ST_ARB;
         ST_ARB:  if (launch) state_d = ST_B0;
         ST_B0:   if (abort) state_d = ST_IDLE; else if (beat_acc) state_d = ST_B1;
         ST_B1:   if (abort) state_d = ST_IDLE; else if (beat_acc) state_d = ST_B2;
         ST_B2:   if (abort || beat_acc) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and datapath: pending bookkeeping, sampling at launch, beat selection.
   always_comb begin
      // A request landing on the launch cycle, or an abandoned TLP, leaves
      // one write-back outstanding; any number of requests fold into it.
      pending_d   = (pending_q && !launch) || update_req || abort;
      done_d      = (state_q == ST_B2) && beat_acc;
      tx_req      = (state_q != ST_IDLE);

      fmt64_d     = launch ? (host_addr[63:32] != 32'h0) : fmt64_q;
      ptr_d       = launch ? hw_pointer : ptr_q;
      addr_d      = launch ? host_addr[63:2] : addr_q;
      id_d        = launch ? cfg_completer_id : id_q;

      td_d        = 64'h0;
      trem_d      = 8'h00;
      sof_n_d     = 1'b1;
      eof_n_d     = 1'b1;
      src_rdy_n_d = 1'b1;
      case (state_d)
         ST_B0: begin
            td_d        = beat0;
            sof_n_d     = 1'b0;
            src_rdy_n_d = 1'b0;
         end
         ST_B1: begin
            td_d        = beat1;
            src_rdy_n_d = 1'b0;
         end
         ST_B2: begin
            td_d        = beat2;
            trem_d      = trem_last_n;
            eof_n_d     = 1'b0;
            src_rdy_n_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign update_done    = done_q;
   assign trn_td         = td_q;
   assign trn_trem_n     = trem_q;
   assign trn_tsof_n     = sof_n_q;
   assign trn_teof_n     = eof_n_q;
   assign trn_tsrc_rdy_n = src_rdy_n_q;
   assign trn_tsrc_dsc_n = 1'b1;

endmodule

// File: tb/tb_hw_pointer_writeback.sv
// Bench for hw_pointer_writeback: arbiter and sink models, a bus monitor,
// and a reference model that lays the TLP out as a DW stream.
module tb_hw_pointer_writeback;

   logic        trn_clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] hw_pointer = 64'h0;
   logic [63:0] host_addr = 64'h0;
   logic [15:0] cfg_completer_id = 16'h0;
   logic        update_req = 1'b0;
   logic        update_done;
   logic        tx_req;
   logic        tx_grant = 1'b0;
   logic [63:0] trn_td;
   logic [7:0]  trn_trem_n;
   logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
   logic        trn_tdst_rdy_n = 1'b0;
   logic        trn_tdst_dsc_n = 1'b1;
   logic [3:0]  trn_tbuf_av = 4'b0010;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] td;
      logic [7:0]  trem;
      logic        sof_n;
      logic        eof_n;
   } beat_t;

   beat_t       acc_q[$];
   logic [63:0] smp_ptr_q[$];
   logic [63:0] smp_addr_q[$];
   logic [15:0] smp_id_q[$];
   int          done_cnt = 0;
   int          hold_evt = 0;
   int          hold_viol = 0;
   int          req_hi_cnt = 0;
   beat_t       prev_beat = '0;
   logic        prev_wait = 1'b0;

   logic        rdy_auto = 1'b1;
   logic        bp_en = 1'b0;
   logic [6:0]  bp_pat = 7'b0101101;  // cycle order 1,0,1,1,0,1,0
   logic [2:0]  bp_idx = 3'd0;
   logic        grant_en = 1'b1;
   logic        ptr_rand = 1'b0;

   always #5 trn_clk = ~trn_clk;

   hw_pointer_writeback #(.BUF_AV_BIT(1)) dut (
      .trn_clk          (trn_clk),
      .reset            (reset),
      .hw_pointer       (hw_pointer),
      .host_addr        (host_addr),
      .cfg_completer_id (cfg_completer_id),
      .update_req       (update_req),
      .update_done      (update_done),
      .tx_req           (tx_req),
      .tx_grant         (tx_grant),
      .trn_td           (trn_td),
      .trn_trem_n       (trn_trem_n),
      .trn_tsof_n       (trn_tsof_n),
      .trn_teof_n       (trn_teof_n),
      .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
      .trn_tsrc_dsc_n   (trn_tsrc_dsc_n),
      .trn_tdst_rdy_n   (trn_tdst_rdy_n),
      .trn_tdst_dsc_n   (trn_tdst_dsc_n),
      .trn_tbuf_av      (trn_tbuf_av)
   );

   // Arbiter: grant follows request and is held until request falls.
   always @(posedge trn_clk) begin
      #1;
      tx_grant = tx_req & grant_en;
   end

   // Sink readiness: always ready, or the back-pressure pattern.
   always @(posedge trn_clk) begin
      #1;
      if (rdy_auto) begin
         if (bp_en) begin
            trn_tdst_rdy_n = bp_pat[bp_idx];
            bp_idx = (bp_idx == 3'd6) ? 3'd0 : bp_idx + 3'd1;
         end else begin
            trn_tdst_rdy_n = 1'b0;
         end
      end
   end

   // Pointer that moves every cycle.
   always @(posedge trn_clk) begin
      #1;
      if (ptr_rand) hw_pointer = {$urandom, $urandom};
   end

   // Bus monitor, sampled mid-cycle.
   always @(negedge trn_clk) begin
      if (reset) begin
         prev_wait = 1'b0;
      end else begin
         if (prev_wait) begin
            hold_evt++;
            if (trn_tsrc_rdy_n || ({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n} != prev_beat))
               hold_viol++;
         end
         if (tx_req && tx_grant && trn_tbuf_av[1] && trn_tsrc_rdy_n) begin
            smp_ptr_q.push_back(hw_pointer);
            smp_addr_q.push_back(host_addr);
            smp_id_q.push_back(cfg_completer_id);
         end
         if (!trn_tsrc_rdy_n && trn_tdst_dsc_n && !trn_tdst_rdy_n)
            acc_q.push_back({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n});
         if (update_done) done_cnt++;
         if (tx_req) req_hi_cnt++;
         prev_wait = !trn_tsrc_rdy_n && trn_tdst_rdy_n && trn_tdst_dsc_n;
         prev_beat = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
      end
   end

   // Reference: TLP as a stream of DWs (header, address, payload bytes in
   // memory order), packed two DWs per beat with a padded odd tail.
   task automatic model_tlp(input logic [63:0] ptr, input logic [63:0] addr,
                            input logic [15:0] id, output logic [2:0][63:0] b,
                            output logic [7:0] trem);
      logic [31:0] dw[$];
      logic [63:0] pay;
      logic        long_addr;
      long_addr = (addr[63:32] != 32'h0);
      dw.push_back({1'b0, (long_addr ? 7'h60 : 7'h40), 24'h000002});
      dw.push_back({id, 16'h00FF});
      if (long_addr) dw.push_back(addr[63:32]);
      dw.push_back(addr[31:0] & 32'hFFFF_FFFC);
      for (int k = 0; k < 8; k++) pay[63 - 8*k -: 8] = ptr[8*k +: 8];
      dw.push_back(pay[63:32]);
      dw.push_back(pay[31:0]);
      trem = (dw.size() % 2 == 1) ? 8'h0F : 8'h00;
      if (dw.size() % 2 == 1) dw.push_back(32'h0);
      for (int i = 0; i < 3; i++) b[i] = {dw[2*i], dw[2*i+1]};
   endtask

   function automatic beat_t mk_beat(input logic [63:0] td, input logic [7:0] trem, input int i);
      return {td, (i == 2) ? trem : 8'h00, (i == 0) ? 1'b0 : 1'b1, (i == 2) ? 1'b0 : 1'b1};
   endfunction

   // Pops one sampled TLP and three accepted beats; missing items become X.
   task automatic fetch_tlp(output beat_t [2:0] got, output logic [2:0][63:0] exp_b,
                            output logic [7:0] exp_trem);
      logic [63:0] p, a;
      logic [15:0] id;
      p = 'x; a = 'x; id = 'x;
      if (smp_ptr_q.size() > 0) begin
         p = smp_ptr_q.pop_front();
         a = smp_addr_q.pop_front();
         id = smp_id_q.pop_front();
      end
      model_tlp(p, a, id, exp_b, exp_trem);
      for (int i = 0; i < 3; i++) got[i] = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge trn_clk);
      #1;
   endtask

   task automatic clear_mon();
      acc_q.delete(); smp_ptr_q.delete(); smp_addr_q.delete(); smp_id_q.delete();
      hold_evt = 0; hold_viol = 0;
   endtask

   task automatic wait_done(input int target, input int budget, output bit ok);
      ok = 0;
      for (int k = 0; k < budget; k++) begin
         if (done_cnt >= target) break;
         tick(1);
      end
      ok = (done_cnt >= target);
   endtask

   task automatic wait_b1(output bit found);
      found = 0;
      for (int k = 0; k < 40; k++) begin
         tick(1);
         if (!trn_tsrc_rdy_n && trn_tsof_n && trn_teof_n) begin
            found = 1;
            break;
         end
      end
   endtask

   task automatic pulse_req();
      update_req = 1'b1;
      tick(1);
      update_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      checks++;
      if ({tx_req, update_done} !== 2'b00) begin
         errors++; $display("FAIL reset_ctrl got %b required 00", {tx_req, update_done});
      end
      checks++;
      if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n} !== 4'b1111) begin
         errors++; $display("FAIL reset_framing got %b required 1111",
                            {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n});
      end
      checks++;
      if ({trn_td, trn_trem_n} !== 72'h0) begin
         errors++; $display("FAIL reset_data got %h/%h required 0/0", trn_td, trn_trem_n);
      end
      reset = 1'b0;
      tick(4);
      checks++;
      if (tx_req !== 1'b0) begin
         errors++; $display("FAIL reset_idle_req got %b required 0", tx_req);
      end
   endtask

   task automatic test_mwr64_basic();
      beat_t [2:0] got;
      logic [2:0][63:0] eb;
      logic [7:0] et;
      clear_mon();
      host_addr = 64'h0000_0001_2345_6780;
      hw_pointer = 64'h1122_3344_5566_7788;
      cfg_completer_id = 16'hABCD;
      update_req = 1'b1;
      tick(1);
      update_req = 1'b0;
      checks++;
      if (tx_req !== 1'b0) begin errors++; $display("FAIL req_latency_n1 got %b required 0", tx_req); end
      tick(1);
      checks++;
      if (tx_req !== 1'b1) begin errors++; $display("FAIL req_latency_n2 got %b required 1", tx_req); end
      tick(1);
      checks++;
      if ({trn_tsrc_rdy_n, trn_tsof_n} !== 2'b00) begin
         errors++; $display("FAIL grant_to_b0 got %b required 00", {trn_tsrc_rdy_n, trn_tsof_n});
      end
      tick(3);
      checks++;
      if ({update_done, tx_req} !== 2'b10) begin
         errors++; $display("FAIL done_pulse got %b required 10", {update_done, tx_req});
      end
      tick(1);
      checks++;
      if (update_done !== 1'b0) begin errors++; $display("FAIL done_single got %b required 0", update_done); end
      fetch_tlp(got, eb, et);
      checks++;
      if ({got[0].td, got[1].td, got[2].td, got[2].trem} !==
          {64'h6000_0002_ABCD_00FF, 64'h0000_0001_2345_6780, 64'h8877_6655_4433_2211, 8'h00}) begin
         errors++; $display("FAIL mwr64_literal got %h %h %h %h", got[0].td, got[1].td, got[2].td, got[2].trem);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i] !== mk_beat(eb[i], et, i)) begin
            errors++; $display("FAIL mwr64_beat%0d got %h required %h", i, got[i], mk_beat(eb[i], et, i));
         end
      end
   endtask

   task automatic test_mwr32();
      beat_t [2:0] got;
      logic [2:0][63:0] eb;
      logic [7:0] et;
      bit ok;
      int base;
      clear_mon();
      base = done_cnt;
      host_addr = 64'h0000_0000_8000_0010;
      hw_pointer = 64'h1122_3344_5566_7788;
      pulse_req();
      wait_done(base + 1, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mwr32_done got %0d required %0d", done_cnt, base + 1); end
      fetch_tlp(got, eb, et);
      checks++;
      if ({got[0].td, got[1].td, got[2].td, got[2].trem} !==
          {64'h4000_0002_ABCD_00FF, 64'h8000_0010_8877_6655, 64'h4433_2211_0000_0000, 8'h0F}) begin
         errors++; $display("FAIL mwr32_literal got %h %h %h %h", got[0].td, got[1].td, got[2].td, got[2].trem);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i] !== mk_beat(eb[i], et, i)) begin
            errors++; $display("FAIL mwr32_beat%0d got %h required %h", i, got[i], mk_beat(eb[i], et, i));
         end
      end
   endtask

   task automatic test_buf_credit();
      bit ok;
      int base;
      clear_mon();
      base = done_cnt;
      trn_tbuf_av = 4'b1101;
      host_addr = {$urandom, $urandom & 32'hFFFF_FFF8};
      hw_pointer = {$urandom, $urandom};
      pulse_req();
      tick(12);
      checks++;
      if ({tx_req, trn_tsrc_rdy_n} !== 2'b11 || acc_q.size() != 0) begin
         errors++; $display("FAIL credit_wait got req/src_rdy_n %b beats %0d required 11 and 0",
                            {tx_req, trn_tsrc_rdy_n}, acc_q.size());
      end
      trn_tbuf_av = 4'b0010;
      wait_done(base + 1, 40, ok);
      checks++;
      if (!ok || acc_q.size() != 3) begin
         errors++; $display("FAIL credit_resume got done %0d beats %0d required %0d and 3",
                            done_cnt, acc_q.size(), base + 1);
      end
   endtask

   task automatic test_back_pressure();
      beat_t [2:0] got;
      logic [2:0][63:0] eb;
      logic [7:0] et;
      bit ok;
      int base;
      clear_mon();
      base = done_cnt;
      host_addr = {$urandom, $urandom & 32'hFFFF_FFF8};
      hw_pointer = {$urandom, $urandom};
      bp_idx = 3'd0;
      bp_en = 1'b1;
      pulse_req();
      wait_done(base + 1, 80, ok);
      bp_en = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_done got %0d required %0d", done_cnt, base + 1); end
      checks++;
      if (hold_viol != 0 || hold_evt == 0) begin
         errors++; $display("FAIL bp_hold got violations %0d stalls %0d required 0 and >0", hold_viol, hold_evt);
      end
      checks++;
      if (acc_q.size() != 3) begin errors++; $display("FAIL bp_count got %0d required 3", acc_q.size()); end
      fetch_tlp(got, eb, et);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i] !== mk_beat(eb[i], et, i)) begin
            errors++; $display("FAIL bp_beat%0d got %h required %h", i, got[i], mk_beat(eb[i], et, i));
         end
      end
   endtask

   task automatic test_coalesce();
      beat_t [2:0] got;
      logic [2:0][63:0] eb;
      logic [7:0] et;
      bit ok, found;
      int base;
      clear_mon();
      base = done_cnt;
      host_addr = {$urandom, $urandom & 32'hFFFF_FFF8};
      ptr_rand = 1'b1;
      pulse_req();
      wait_b1(found);
      checks++;
      if (!found) begin errors++; $display("FAIL coal_b1 got no B1 required B1 within 40 cycles"); end
      rdy_auto = 1'b0;
      trn_tdst_rdy_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         update_req = 1'b1;
         tick(1);
         update_req = 1'b0;
         tick(1);
      end
      rdy_auto = 1'b1;
      trn_tdst_rdy_n = 1'b0;
      wait_done(base + 2, 80, ok);
      tick(30);
      ptr_rand = 1'b0;
      checks++;
      if (done_cnt != base + 2 || tx_req !== 1'b0) begin
         errors++; $display("FAIL coal_count got done %0d req %b required %0d and 0", done_cnt, tx_req, base + 2);
      end
      checks++;
      if (hold_viol != 0 || acc_q.size() != 6) begin
         errors++; $display("FAIL coal_stable got violations %0d beats %0d required 0 and 6", hold_viol, acc_q.size());
      end
      for (int t = 0; t < 2; t++) begin
         fetch_tlp(got, eb, et);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== mk_beat(eb[i], et, i)) begin
               errors++; $display("FAIL coal_tlp%0d_beat%0d got %h required %h", t, i, got[i], mk_beat(eb[i], et, i));
            end
         end
      end
   endtask

   task automatic test_discontinue();
      beat_t [2:0] got;
      logic [2:0][63:0] eb;
      logic [7:0] et;
      bit ok, found;
      int base;
      clear_mon();
      base = done_cnt;
      host_addr = {$urandom, $urandom & 32'hFFFF_FFF8};
      ptr_rand = 1'b1;
      pulse_req();
      wait_b1(found);
      trn_tdst_dsc_n = 1'b0;
      update_req = 1'b1;
      tick(1);
      trn_tdst_dsc_n = 1'b1;
      update_req = 1'b0;
      checks++;
      if (!found || {tx_req, trn_tsrc_rdy_n, update_done} !== 3'b010) begin
         errors++; $display("FAIL dsc_abort got req/src_rdy_n/done %b required 010",
                            {tx_req, trn_tsrc_rdy_n, update_done});
      end
      wait_done(base + 1, 60, ok);
      tick(25);
      ptr_rand = 1'b0;
      checks++;
      if (done_cnt != base + 1 || smp_ptr_q.size() != 2 || acc_q.size() != 4) begin
         errors++; $display("FAIL dsc_retry got done %0d tlps %0d beats %0d required %0d 2 4",
                            done_cnt, smp_ptr_q.size(), acc_q.size(), base + 1);
      end
      void'(acc_q.pop_front());
      void'(smp_ptr_q.pop_front()); void'(smp_addr_q.pop_front()); void'(smp_id_q.pop_front());
      fetch_tlp(got, eb, et);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i] !== mk_beat(eb[i], et, i)) begin
            errors++; $display("FAIL dsc_beat%0d got %h required %h", i, got[i], mk_beat(eb[i], et, i));
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int base;
      clear_mon();
      base = done_cnt;
      host_addr = 64'h0000_0000_0000_1000;
      hw_pointer = {$urandom, $urandom};
      update_req = 1'b1;
      tick(1);
      update_req = 1'b0;
      tick(1);
      update_req = 1'b1;  // lands on the cycle the request leaves arbitration
      tick(1);
      update_req = 1'b0;
      wait_done(base + 2, 60, ok);
      tick(20);
      checks++;
      if (done_cnt != base + 2 || acc_q.size() != 6) begin
         errors++; $display("FAIL b2b_count got done %0d beats %0d required %0d and 6", done_cnt, acc_q.size(), base + 2);
      end
   endtask

   task automatic test_random();
      beat_t [2:0] got;
      logic [2:0][63:0] eb;
      logic [7:0] et;
      bit ok;
      int base;
      for (int n = 0; n < 8; n++) begin
         clear_mon();
         base = done_cnt;
         host_addr = {($urandom_range(0, 1) == 1) ? $urandom : 32'h0, $urandom & 32'hFFFF_FFF8};
         hw_pointer = {$urandom, $urandom};
         cfg_completer_id = 16'($urandom);
         bp_en = 1'($urandom_range(0, 1));
         pulse_req();
         wait_done(base + 1, 80, ok);
         bp_en = 1'b0;
         checks++;
         if (!ok || hold_viol != 0) begin
            errors++; $display("FAIL rand%0d_done got done %0d violations %0d required %0d and 0", n, done_cnt, hold_viol, base + 1);
         end
         fetch_tlp(got, eb, et);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== mk_beat(eb[i], et, i)) begin
               errors++; $display("FAIL rand%0d_beat%0d got %h required %h", n, i, got[i], mk_beat(eb[i], et, i));
            end
         end
      end
   endtask

   task automatic test_reset_mid_tlp();
      bit ok, found;
      int base, req_cnt;
      clear_mon();
      host_addr = {$urandom, $urandom & 32'hFFFF_FFF8};
      hw_pointer = {$urandom, $urandom};
      pulse_req();
      wait_b1(found);
      reset = 1'b1;
      tick(1);
      checks++;
      if (!found || {tx_req, update_done, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n} !== 6'b001111
          || {trn_td, trn_trem_n} !== 72'h0) begin
         errors++; $display("FAIL rst_mid got ctrl %b td %h trem %h required 001111 0 0",
                            {tx_req, update_done, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n},
                            trn_td, trn_trem_n);
      end
      reset = 1'b0;
      req_cnt = req_hi_cnt;
      tick(25);
      checks++;
      if (req_hi_cnt != req_cnt || tx_req !== 1'b0) begin
         errors++; $display("FAIL rst_no_resend got req cycles %0d required 0", req_hi_cnt - req_cnt);
      end
      clear_mon();
      base = done_cnt;
      pulse_req();
      wait_done(base + 1, 40, ok);
      checks++;
      if (!ok || acc_q.size() != 3) begin
         errors++; $display("FAIL rst_recover got done %0d beats %0d required %0d and 3", done_cnt, acc_q.size(), base + 1);
      end
   endtask

   initial begin
      test_reset();
      test_mwr64_basic();
      test_mwr32();
      test_buf_credit();
      test_back_pressure();
      test_coalesce();
      test_discontinue();
      test_back_to_back();
      test_random();
      test_reset_mid_tlp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
